operand_fetch: RTL

- Register-read stage directly upstream of the 16x16 register file `regs`.
- Accepts one decoded instruction at a time over a valid/ready handshake and issues up to two register reads.
- Absorbs the register file's 2-edge read latency and forwards writeback values the file has not yet made visible.
- Presents the instruction plus both operands to execute over a valid/ready handshake, and owns the writeback path into `regs`.

---
 rtl/operand_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Register-read stage in front of the 16x16 regfile: issues reads, hides the
// 2-edge read latency, forwards in-flight writebacks and hands operands to execute.
module operand_fetch #(
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [3:0]         in_ra,
  input  logic               in_ra_en,
  input  logic [3:0]         in_rb,
  input  logic               in_rb_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [15:0]        out_a,
  output logic [15:0]        out_b,
  input  logic               wb_valid,
  input  logic [3:0]         wb_addr,
  input  logic [15:0]        wb_data,
  output logic               reg_ren0,
  output logic [3:0]         reg_raddr0,
  input  logic [15:0]        reg_rdata0,
  output logic               reg_ren1,
  output logic [3:0]         reg_raddr1,
  input  logic [15:0]        reg_rdata1,
  output logic               reg_wen,
  output logic [3:0]         reg_waddr,
  output logic [15:0]        reg_wdata
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  typedef enum logic [1:0] {IDLE, WAIT1, WAIT2, DONE} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [AW-1:0] ra_q, rb_q;
  logic          ra_en_q, rb_en_q;
  logic          byp_a_v, byp_b_v;
  logic [DW-1:0] byp_a_d, byp_b_d;
  logic          hit_in_a, hit_in_b, hit_a, hit_b;
  logic [DW-1:0] sel_a, sel_b;

  // Writeback match against the incoming sources (accept edge) and the latched ones
  assign hit_in_a = wb_valid && in_ra_en && (wb_addr == in_ra);
  assign hit_in_b = wb_valid && in_rb_en && (wb_addr == in_rb);
  assign hit_a    = wb_valid && ra_en_q && (wb_addr == ra_q);
  assign hit_b    = wb_valid && rb_en_q && (wb_addr == rb_q);

  // Final operand pick at the capture edge: live writeback > bypass > regfile
  assign sel_a = !ra_en_q ? DW'(0) : hit_a ? wb_data : byp_a_v ? byp_a_d : reg_rdata0;
  assign sel_b = !rb_en_q ? DW'(0) : hit_b ? wb_data : byp_b_v ? byp_b_d : reg_rdata1;

  assign reg_ren0   = accept && in_ra_en;
  assign reg_raddr0 = in_ra;
  assign reg_ren1   = accept && in_rb_en;
  assign reg_raddr1 = in_rb;

  // Writeback is a straight pass-through, gated off while reset is held
  assign reg_wen   = wb_valid && rst_n;
  assign reg_waddr = wb_addr;
  assign reg_wdata = wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT1;
      WAIT1:   state_nxt = WAIT2;
      WAIT2:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? WAIT1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= INSTR_W'(0);
      out_a     <= DW'(0);
      out_b     <= DW'(0);
      ra_q      <= AW'(0);
      rb_q      <= AW'(0);
      ra_en_q   <= 1'b0;
      rb_en_q   <= 1'b0;
      byp_a_v   <= 1'b0;
      byp_b_v   <= 1'b0;
      byp_a_d   <= DW'(0);
      byp_b_d   <= DW'(0);
    end else begin
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        out_instr <= in_instr;
        ra_q      <= in_ra;
        rb_q      <= in_rb;
        ra_en_q   <= in_ra_en;
        rb_en_q   <= in_rb_en;
        byp_a_v   <= hit_in_a;
        byp_b_v   <= hit_in_b;
        byp_a_d   <= wb_data;
        byp_b_d   <= wb_data;
      end else if (state == WAIT1) begin
        // A write here lands in the regfile too late for this read; keep the newest
        if (hit_a) begin
          byp_a_v <= 1'b1;
          byp_a_d <= wb_data;
        end
        if (hit_b) begin
          byp_b_v <= 1'b1;
          byp_b_d <= wb_data;
        end
      end else if (state == WAIT2) begin
        out_a <= sel_a;
        out_b <= sel_b;
      end
    end
  end

endmodule
